// File: rtl/pwm_audio_out.sv
// -----------------------------------------------------------------------------
// pwm_audio_out
//
// Final output stage of the audio path. Plays the filtered 8-bit sample stream
// on a single-pin PWM DAC: one 256-clock period per duty value. The duty is
// only ever changed on the last clock of a period, so the pin never glitches
// mid-period. A soft-start/soft-stop ramp FSM walks the duty slowly between 0
// and MID_CODE on enable/disable to avoid audible pops.
//
// Parameters:
//   RAMP_DIV  PWM periods per 1-LSB ramp step (legal 1..16)
//   MID_CODE  ramp target on start-up; hand-over point into RUN
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   enable        level: 1 = play, 0 = ramp down and park the pin low
//   sample_valid  one-cycle strobe qualifying sample_in
//   sample_in     unsigned filtered audio sample
//   pwm_out       registered PWM pin drive
//   period_start  one-cycle pulse on the first clock of each PWM period
//   running       high while the FSM is in RUN
//   idle          high while the FSM is in OFF
//
// Optional feature (macro PWM_DITHER_EN):
//   When defined, an 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01) steps
//   once per period and its LSB is added, saturating, to the RUN duty.
//   When undefined no LFSR exists and the RUN duty is the pending sample.
// -----------------------------------------------------------------------------
module pwm_audio_out #(
  parameter int         RAMP_DIV = 4,
  parameter logic [7:0] MID_CODE = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] sample_in,
  output logic       pwm_out,
  output logic       period_start,
  output logic       running,
  output logic       idle
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  // Last value of the period divider; a ramp step fires when it is reached.
  localparam logic [3:0] DIV_LAST = 4'(RAMP_DIV - 1);

  // Registered state
  logic [7:0] r_cnt;
  logic [7:0] r_pending;
  logic [7:0] r_active;
  logic [7:0] r_ramp;
  logic [3:0] r_div;
  state_t     r_state;
  logic       r_pwm;
  logic       r_period_start;
  logic       r_running;
  logic       r_idle;

  // Combinational helpers
  logic       w_boundary;
  logic       w_step;
  logic [7:0] w_ramp_inc;
  logic [7:0] w_ramp_dec;
  logic [7:0] w_run_duty;
  state_t     w_state_nxt;
  state_t     w_state_after;
  logic [7:0] w_ramp_nxt;
  logic [3:0] w_div_nxt;
  logic [7:0] w_active_nxt;

  // Everything period-related happens on the edge that closes the period.
  assign w_boundary = (r_cnt == 8'hFF);
  assign w_step     = (r_div == DIV_LAST);

  // Ramp never wraps: clamp at MID_CODE going up (also catches a ramp that
  // was reversed while still above MID_CODE) and at zero going down.
  assign w_ramp_inc = (r_ramp >= MID_CODE) ? MID_CODE : (r_ramp + 8'd1);
  assign w_ramp_dec = (r_ramp == 8'h00) ? 8'h00 : (r_ramp - 8'd1);

`ifdef PWM_DITHER_EN
  logic [7:0] r_lfsr;

  // One right-shift step of the Galois LFSR, feedback mask for taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] shifted;
    shifted = {1'b0, v[7:1]};
    if (v[0]) begin
      lfsr_next = shifted ^ 8'hB8;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

  // Add one LSB of dither without letting 8'hFF wrap to zero.
  function automatic logic [7:0] sat_add1(input logic [7:0] a, input logic b);
    logic [8:0] sum;
    sum = {1'b0, a} + {8'h00, b};
    if (sum[8]) begin
      sat_add1 = 8'hFF;
    end else begin
      sat_add1 = sum[7:0];
    end
  endfunction

  assign w_run_duty = sat_add1(r_pending, r_lfsr[0]);

  // Dither source: advances once per PWM period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 8'h01;
    end else if (w_boundary) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  assign w_run_duty = r_pending;
`endif

  // Next-state / next-duty decode, only committed on a period boundary.
  // On an edge where the state changes, the duty still follows the rule of
  // the state being left, and no ramp step is taken on a direction reversal.
  always_comb begin
    w_state_nxt  = r_state;
    w_ramp_nxt   = r_ramp;
    w_div_nxt    = r_div;
    w_active_nxt = r_active;
    case (r_state)
      ST_OFF: begin
        w_active_nxt = 8'h00;
        w_div_nxt    = 4'd0;
        w_ramp_nxt   = 8'h00;
        if (enable) begin
          w_state_nxt = ST_RAMP_UP;
        end else begin
          w_state_nxt = ST_OFF;
        end
      end
      ST_RAMP_UP: begin
        if (!enable) begin
          w_state_nxt  = ST_RAMP_DOWN;
          w_div_nxt    = 4'd0;
          w_active_nxt = r_ramp;
        end else if (w_step) begin
          w_div_nxt    = 4'd0;
          w_ramp_nxt   = w_ramp_inc;
          w_active_nxt = w_ramp_inc;
          if (w_ramp_inc == MID_CODE) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_RAMP_UP;
          end
        end else begin
          w_div_nxt    = r_div + 4'd1;
          w_active_nxt = r_ramp;
        end
      end
      ST_RUN: begin
        w_active_nxt = w_run_duty;
        w_div_nxt    = 4'd0;
        if (!enable) begin
          // Start the fade from the sample that was just playing.
          w_state_nxt = ST_RAMP_DOWN;
          w_ramp_nxt  = r_pending;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RAMP_DOWN: begin
        if (enable) begin
          w_state_nxt  = ST_RAMP_UP;
          w_div_nxt    = 4'd0;
          w_active_nxt = r_ramp;
        end else if (w_step) begin
          w_div_nxt    = 4'd0;
          w_ramp_nxt   = w_ramp_dec;
          w_active_nxt = w_ramp_dec;
          if (w_ramp_dec == 8'h00) begin
            w_state_nxt = ST_OFF;
          end else begin
            w_state_nxt = ST_RAMP_DOWN;
          end
        end else begin
          w_div_nxt    = r_div + 4'd1;
          w_active_nxt = r_ramp;
        end
      end
      default: begin
        w_state_nxt  = ST_OFF;
        w_ramp_nxt   = 8'h00;
        w_div_nxt    = 4'd0;
        w_active_nxt = 8'h00;
      end
    endcase
  end

  // State the FSM will hold after this edge; drives the status flags.
  assign w_state_after = w_boundary ? w_state_nxt : r_state;

  // FSM state register with ramp, divider and duty, stepped per period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_ramp   <= 8'h00;
      r_div    <= 4'd0;
      r_active <= 8'h00;
    end else if (w_boundary) begin
      r_state  <= w_state_nxt;
      r_ramp   <= w_ramp_nxt;
      r_div    <= w_div_nxt;
      r_active <= w_active_nxt;
    end else begin
      r_state  <= r_state;
      r_ramp   <= r_ramp;
      r_div    <= r_div;
      r_active <= r_active;
    end
  end

  // Period counter, sample capture, PWM comparator and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= 8'h00;
      r_pending      <= MID_CODE;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_running      <= 1'b0;
      r_idle         <= 1'b1;
    end else begin
      r_cnt          <= r_cnt + 8'd1;
      r_period_start <= w_boundary;
      // Output lags the counter by one clock; with cnt==255 never below an
      // 8-bit duty, a full-scale duty gives 255 high clocks out of 256.
      r_pwm          <= (r_cnt < r_active);
      r_running      <= (w_state_after == ST_RUN);
      r_idle         <= (w_state_after == ST_OFF);
      if (sample_valid) begin
        r_pending <= sample_in;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign running      = r_running;
  assign idle         = r_idle;

endmodule

// File: tb/tb_pwm_audio_out.sv
// -----------------------------------------------------------------------------
// tb_pwm_audio_out
//
// Bench for pwm_audio_out (RAMP_DIV=1, MID_CODE=8'h80). A period-level
// reference model predicts, at every period boundary, the duty and the FSM
// status for the coming period and queues it. A monitor measures the high
// time and length of each real PWM period between period_start pulses and
// compares against the queue. Directed phases follow the test plan, then a
// short randomized phase toggles enable and strobes random samples.
// -----------------------------------------------------------------------------
module tb_pwm_audio_out;

  localparam int RDIV = 1;
  localparam int MID  = 128;

  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sample_valid;
  logic [7:0] sample_in;
  logic       pwm_out;
  logic       period_start;
  logic       running;
  logic       idle;

  pwm_audio_out #(.RAMP_DIV(RDIV), .MID_CODE(8'h80)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .running      (running),
    .idle         (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int active;
    int run;
    int idl;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (per-period view)
  int m_cnt     = 0;
  int m_state   = M_OFF;
  int m_ramp    = 0;
  int m_div     = 0;
  int m_active  = 0;
  int m_pending = MID;
  int m_lfsr    = 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int run_duty(input int pend, input int lf);
    int d;
    d = pend;
`ifdef PWM_DITHER_EN
    d = pend + (lf & 1);
    if (d > 255) d = 255;
`endif
    return d;
  endfunction

  // Decide duty and state for the next period from the rules in plain terms.
  task automatic model_boundary(input int en);
    case (m_state)
      M_OFF: begin
        m_active = 0;
        if (en != 0) begin
          m_state = M_UP; m_ramp = 0; m_div = 0;
        end
      end
      M_UP: begin
        if (en == 0) begin
          m_state = M_DOWN; m_div = 0; m_active = m_ramp;
        end else if (m_div == RDIV - 1) begin
          m_div = 0;
          m_ramp = (m_ramp >= MID) ? MID : m_ramp + 1;
          m_active = m_ramp;
          if (m_ramp == MID) m_state = M_RUN;
        end else begin
          m_div++; m_active = m_ramp;
        end
      end
      M_RUN: begin
        m_active = run_duty(m_pending, m_lfsr);
        if (en == 0) begin
          m_state = M_DOWN; m_ramp = m_pending; m_div = 0;
        end
      end
      default: begin
        if (en != 0) begin
          m_state = M_UP; m_div = 0; m_active = m_ramp;
        end else if (m_div == RDIV - 1) begin
          m_div = 0;
          m_ramp = (m_ramp == 0) ? 0 : m_ramp - 1;
          m_active = m_ramp;
          if (m_ramp == 0) m_state = M_OFF;
        end else begin
          m_div++; m_active = m_ramp;
        end
      end
    endcase
    m_lfsr = ((m_lfsr & 1) != 0) ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
  endtask

  // Model process: sees the same inputs as the DUT on each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cnt = 0; m_state = M_OFF; m_ramp = 0; m_div = 0;
        m_active = 0; m_pending = MID; m_lfsr = 1;
        exp_q.delete();
        e.active = 0; e.run = 0; e.idl = 1;
        exp_q.push_back(e);
      end else begin
        if (m_cnt == 255) begin
          model_boundary(int'(enable));
          e.active = m_active;
          e.run = (m_state == M_RUN) ? 1 : 0;
          e.idl = (m_state == M_OFF) ? 1 : 0;
          exp_q.push_back(e);
        end
        if (sample_valid) m_pending = int'(sample_in);
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  end

  // Monitor: measures each PWM period and pops the matching prediction.
  bit   mon_rst = 1'b0;
  bit   mon_on  = 1'b0;
  int   acc     = 0;
  int   len     = 0;
  exp_t cur;

  initial begin
    forever begin
      @(posedge clk);
      mon_rst = !rst_n;
      @(negedge clk);
      if (mon_rst) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_running", int'(running), 0);
        check("rst_period_start", int'(period_start), 0);
        acc = 0; len = 1; mon_on = 1'b1;
      end else if (mon_on) begin
        if (period_start) begin
          check("period_len", len, 256);
          check("high_time", acc, cur.active);
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard_empty: got period_start, expected no period (t=%0t)", $time);
          end else begin
            cur = exp_q.pop_front();
            check("running", int'(running), cur.run);
            check("idle", int'(idle), cur.idl);
          end
          acc = int'(pwm_out); len = 1;
        end else begin
          acc += int'(pwm_out);
          len++;
          if (len > 260) begin
            check("period_timeout", len, 256);
            acc = 0; len = 1;
          end
        end
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cnt(input int v);
    int g;
    g = 0;
    do begin
      step_clk();
      g++;
    end while (m_cnt != v && g < 600);
    if (m_cnt != v) check("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic wait_periods(input int n);
    repeat (n) wait_cnt(0);
  endtask

  task automatic strobe(input logic [7:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    step_clk();
    sample_valid = 1'b0;
  endtask

  // Bounded wait on a DUT status flag: which=0 running, which=1 idle.
  task automatic wait_flag(input int which, input int budget_periods, input string name);
    int g;
    g = 0;
    while (((which == 0) ? running : idle) != 1'b1 && g < budget_periods * 256) begin
      step_clk();
      g++;
    end
    check(name, int'((which == 0) ? running : idle), 1);
  endtask

  initial begin
    bit any_hi;
    bit any_bad;
    int t;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Disabled: pin quiet and status OFF for 2000 clocks.
    any_hi = 1'b0; any_bad = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      any_hi  = any_hi | pwm_out;
      any_bad = any_bad | !idle | running;
    end
    check("off_pwm_quiet", int'(any_hi), 0);
    check("off_status", int'(any_bad), 0);
    step_clk();

    // Soft start: 128 one-step periods to RUN.
    enable = 1'b1;
    t = 0;
    while (!running && t < 131 * 256) begin
      step_clk();
      t++;
    end
    check("ramp_up_time_in_window", int'(t >= 127 * 256 && t <= 130 * 256), 1);

    // RUN sample handling.
    wait_cnt(100);
    strobe(8'h40);
    wait_periods(2);
    wait_cnt(20);
    strobe(8'hFF);
    wait_periods(2);
    wait_cnt(20);
    strobe(8'h00);
    wait_periods(2);
    wait_cnt(50);
    strobe(8'h10);
    strobe(8'h20);
    wait_periods(2);

    // Reversal while above MID_CODE saturates back to MID_CODE.
    strobe(8'hC0);
    wait_periods(2);
    enable = 1'b0;
    wait_periods(5);
    enable = 1'b1;
    wait_flag(0, 10, "sat_reenter_run");
    wait_periods(2);

    // Fade down from 8'hC0, re-enable at ramp=100, climb back to RUN.
    enable = 1'b0;
    t = 0;
    while (!(m_ramp == 100 && m_state == M_DOWN) && t < 120 * 256) begin
      step_clk();
      t++;
    end
    check("reach_ramp_100", m_ramp, 100);
    enable = 1'b1;
    wait_flag(0, 40, "reenter_run_from_100");
    wait_periods(1);

    // Complete fade to OFF from a small sample.
    strobe(8'h08);
    wait_periods(2);
    enable = 1'b0;
    wait_flag(1, 20, "fade_to_idle");
    wait_periods(1);

    // Reset pulse in the middle of a ramp-up period.
    enable = 1'b1;
    wait_periods(4);
    wait_cnt(37);
    rst_n = 1'b0;
    step_clk();
    rst_n = 1'b1;
    wait_periods(3);
    enable = 1'b0;
    wait_flag(1, 20, "idle_after_reset_ramp");

    // Randomized enable and sample traffic.
    for (int p = 0; p < 20; p++) begin
      enable = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 256; c++) begin
        sample_in = 8'($urandom_range(0, 255));
        sample_valid = ($urandom_range(0, 31) == 0);
        step_clk();
      end
    end
    sample_valid = 1'b0;
    enable = 1'b0;
    wait_periods(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
Final output stage after the output lowpass. It consumes the filtered 8-bit sample stream and drives a single-pin PWM DAC: one 256-clock period per duty value, updated glitch-free at period boundaries. A soft-start/soft-stop ramp FSM suppresses pops on enable and disable.

Parameters:
RAMP_DIV, 4, number of PWM periods per 1-LSB ramp step (legal 1..16)
MID_CODE, 8'h80, ramp target on start-up and hand-over point into RUN

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
enable  input  1  level; 1 = output requested, 0 = ramp down and park low
sample_valid  input  1  one-cycle strobe qualifying sample_in
sample_in  input  8  unsigned filtered audio sample from the lowpass stage
pwm_out  output  1  registered PWM pin drive
period_start  output  1  one-cycle pulse on the first clock of each PWM period
running  output  1  high while FSM is in RUN
idle  output  1  high while FSM is in OFF

Behaviour:
- Reset: synchronous, active-low; clk and rst_n only, no other clock or reset. Reset takes effect on the clk edge while rst_n=0, including mid-period or mid-ramp. cnt=0, pending=MID_CODE, active=0, ramp=0, div=0, state=OFF. pwm_out=0, period_start=0, running=0, idle=1 on the first edge after reset.
- Counter: 8-bit cnt, free-running 0..255 and wrapping. Period = 256 clk.
- period_start: registered; high for the cycle after the edge where cnt goes 255->0.
- Sample capture: on sample_valid, pending <= sample_in, in any state. Multiple strobes within one period: last one wins. No strobe in a period: pending is held and repeats.
- Duty update: occurs only on the edge where cnt==255, so the next period uses the new active value.
  - RUN: active <= pending.
  - RAMP_UP / RAMP_DOWN: active <= ramp after the step is applied.
  - OFF: active <= 0.
- pwm_out: registered, pwm_out <= (cnt < active), evaluated every edge.
  - active=0 gives constant 0.
  - active=255 gives 255 high clocks of 256.
  - Output lags cnt by one clock.
- FSM: states OFF, RAMP_UP, RUN, RAMP_DOWN. All transitions and ramp steps are evaluated only on the cnt==255 edge. div counts periods 0..RAMP_DIV-1, and a step fires when div==RAMP_DIV-1.
  - OFF: enable=1 -> RAMP_UP with ramp=0, div=0.
  - RAMP_UP: on step, ramp+1. When ramp reaches MID_CODE -> RUN. enable=0 -> RAMP_DOWN, keeping the current ramp value.
  - RUN: enable=0 -> RAMP_DOWN with ramp <= pending, so the ramp starts from the last played sample.
  - RAMP_DOWN: on step, ramp-1. When ramp reaches 0 -> OFF. enable=1 -> RAMP_UP, keeping the current ramp value.
- Boundaries:
  - The ramp never wraps. It saturates at 0 and at MID_CODE, including when RAMP_DOWN starts from a value above MID_CODE and enable returns.
  - sample_valid and a transition on the same edge: the capture still happens; the duty uses the pre-edge pending value.
- Ramp time 0->MID_CODE: MID_CODE*RAMP_DIV*256 clk (131072 clk at default).

Optional Feature:
PWM_DITHER_EN.
- Defined:
  - Adds an 8-bit Galois LFSR: taps x^8+x^6+x^5+x^4+1, seed 8'h01 on reset.
  - The LFSR advances once per cnt==255 edge.
  - In RUN, the duty update becomes active <= min(pending + lfsr[0], 255).
  - Ramp states are unaffected.
- Undefined: no LFSR logic; behaviour exactly as above.

Test Plan:
- Reset then enable=0 for 2000 clk -> pwm_out=0 throughout; idle=1, running=0; period_start pulses every 256 clk.
- RAMP_DIV=1, enable=1 from OFF -> running rises after 128 periods (32768 clk ±1 period); during the ramp, high-time per period rises 0,1,2,...,128.
- In RUN, sample_valid with sample_in=8'h40 at cnt=100 -> current period unchanged; next period has 64 high clocks starting one clk after period_start.
- In RUN, sample_in=8'hFF -> 255 high per period; sample_in=8'h00 -> constant 0. Two strobes in one period (8'h10 then 8'h20) -> next period 32 high.
- RUN with pending=8'hC0, RAMP_DIV=1, enable=0 -> high-time 191,190,...,0 per period, then idle=1. Re-enable when ramp=100 -> counts back up 101..128, then RUN.
- Assert rst_n=0 for one clk mid-RAMP_UP at cnt=37 -> next cycle pwm_out=0, idle=1, cnt restarts at 0. With PWM_DITHER_EN defined and pending=8'hFF -> high-time never exceeds 255.
